// File: rtl/hc21_ste_pkg.sv
// Shared types and helper functions for the HC21 STE attention / bus-master arbiter.
package hc21_ste_pkg;

  localparam int MAX_ATN = 16;
  localparam int MAX_MST = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic int prio_enc(input logic [MAX_ATN-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_ATN; i++) begin
      if (v[i[3:0]]) r = i;
    end
    return r;
  endfunction

  // First requester strictly after 'last', wrapping modulo n; returns 'last' if none.
  function automatic int rr_pick(input logic [MAX_MST-1:0] req, input int last, input int n);
    int  idx;
    bit  found;
    int  r;
    r     = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_MST; i++) begin
      idx = (last + i) % n;
      if (!found && (i <= n) && req[idx[2:0]]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hc21_ste_arbiter_if.sv
// STE backplane / HC21 CPU signal bundle seen by the attention and bus-master arbiter.
interface hc21_ste_arbiter_if #(
  parameter int N_ATN = 8,
  parameter int N_MST = 2,
  parameter int AW    = $clog2(N_ATN)
);

  logic [N_ATN-1:0] atnrq_n;
  logic [N_ATN-2:0] atn_mask;
  logic [N_MST-1:0] busrq_n;
  logic             cpu_busak_n;
  logic             cpu_iack_n;
  logic [AW-1:0]    addr;
  logic             addr_oe;
  logic [N_MST-1:0] busak_n;
  logic             cpu_busrq_n;
  logic             cpu_int_n;
  logic             cpu_nmi_n;

  // master: backplane + CPU side driving requests and acknowledges
  modport master (
    output atnrq_n, atn_mask, busrq_n, cpu_busak_n, cpu_iack_n,
    input  addr, addr_oe, busak_n, cpu_busrq_n, cpu_int_n, cpu_nmi_n
  );

  // slave: the arbiter itself
  modport slave (
    input  atnrq_n, atn_mask, busrq_n, cpu_busak_n, cpu_iack_n,
    output addr, addr_oe, busak_n, cpu_busrq_n, cpu_int_n, cpu_nmi_n
  );

endinterface

// File: rtl/hc21_sync2.sv
// Two-flop synchroniser for active-low asynchronous request lines; resets to inactive (1).
module hc21_sync2 #(
  parameter int W = 1
) (
  input  logic         sysclk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hc21_ste_arbiter.sv
// STE attention handler (INT/NMI + frozen vector on IACK) and round-robin bus-master arbiter.
module hc21_ste_arbiter
  import hc21_ste_pkg::*;
#(
  parameter int N_ATN = 8,
  parameter int N_MST = 2,
  parameter int AW    = $clog2(N_ATN)
) (
  input logic               sysclk,
  input logic               reset_n,
  hc21_ste_arbiter_if.slave bus
);

  localparam int LW = $clog2(N_MST);

  logic [N_ATN-1:0]   atnrq_s;
  logic [N_MST-1:0]   busrq_s;
  logic [N_ATN-1:0]   atn;
  logic [N_MST-1:0]   req;
  logic [N_ATN-2:0]   pend;
  logic [MAX_ATN-1:0] pend_ext;
  logic [MAX_MST-1:0] req_ext;
  logic [AW-1:0]      vec;
  logic [LW-1:0]      pick;

  logic [AW-1:0]      addr_q;
  logic               addr_oe_q;
  logic               int_n_q;
  logic               nmi_n_q;

  arb_state_t         state_q, state_d;
  logic [LW-1:0]      win_q, win_d;
  logic [LW-1:0]      last_q, last_d;
  logic               busrq_n_q, busrq_n_d;
  logic [N_MST-1:0]   busak_n_q, busak_n_d;

  hc21_sync2 #(.W(N_ATN)) u_sync_atn (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .d_i     (bus.atnrq_n),
    .q_o     (atnrq_s)
  );

  hc21_sync2 #(.W(N_MST)) u_sync_busrq (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .d_i     (bus.busrq_n),
    .q_o     (busrq_s)
  );

  assign atn  = ~atnrq_s;
  assign req  = ~busrq_s;
  assign pend = atn[N_ATN-1:1] & bus.atn_mask;

  // Pending lines are placed at their line numbers so the encoder returns the line index.
  always_comb begin
    pend_ext              = '0;
    pend_ext[N_ATN-1:1]   = pend;
    vec                   = AW'(prio_enc(pend_ext));
    req_ext               = '0;
    req_ext[N_MST-1:0]    = req;
    pick                  = LW'(rr_pick(req_ext, int'(last_q), N_MST));
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      int_n_q <= 1'b1;
      nmi_n_q <= 1'b1;
    end else begin
      int_n_q <= ~|pend;
      nmi_n_q <= ~atn[0];
    end
  end

  // Vector is captured once per acknowledge and held until IACK is released.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      addr_oe_q <= 1'b0;
    end else if (!bus.cpu_iack_n) begin
      if (!addr_oe_q) begin
        addr_q    <= vec;
        addr_oe_q <= 1'b1;
      end
    end else begin
      addr_oe_q <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      last_q    <= LW'(N_MST - 1);
      busrq_n_q <= 1'b1;
      busak_n_q <= '1;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      busrq_n_q <= busrq_n_d;
      busak_n_q <= busak_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    busrq_n_d = 1'b1;
    busak_n_d = '1;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        busrq_n_d = 1'b0;
        // A master withdrawing before the CPU yields aborts without granting.
        if (!req[win_q]) begin
          state_d = RELEASE;
        end else if (!bus.cpu_busak_n) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        busrq_n_d        = 1'b0;
        busak_n_d[win_q] = 1'b0;
        if (!req[win_q]) begin
          state_d = RELEASE;
          last_d  = win_q;
        end
      end
      RELEASE: begin
        if (bus.cpu_busak_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.addr        = addr_q;
  assign bus.addr_oe     = addr_oe_q;
  assign bus.busak_n     = busak_n_q;
  assign bus.cpu_busrq_n = busrq_n_q;
  assign bus.cpu_int_n   = int_n_q;
  assign bus.cpu_nmi_n   = nmi_n_q;

endmodule

// File: tb/tb_hc21_ste_arbiter.sv
// Directed-vector bench for hc21_ste_arbiter (N_ATN=8, N_MST=2) with hand-computed expectations.
module tb_hc21_ste_arbiter;

  logic clk;
  logic reset_n;
  logic cpu_auto;
  int   n_checks;
  int   n_errors;
  int   low_cycles;
  int   both_low_cycles;
  int   who;
  int   g0;

  hc21_ste_arbiter_if #(.N_ATN(8), .N_MST(2)) bus ();

  hc21_ste_arbiter #(.N_ATN(8), .N_MST(2)) dut (
    .sysclk  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busak_n != 2'b11) low_cycles <= low_cycles + 1;
    if (bus.busak_n == 2'b00) both_low_cycles <= both_low_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance n cycles; the CPU model mirrors cpu_busrq_n onto cpu_busak_n one cycle late.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cpu_auto) bus.cpu_busak_n = bus.cpu_busrq_n;
    end
  endtask

  task automatic wait_grant(output int w);
    w = -1;
    for (int c = 0; c < 60 && w < 0; c++) begin
      tick(1);
      if (bus.busak_n == 2'b10) w = 0;
      else if (bus.busak_n == 2'b01) w = 1;
    end
    if (w < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_wait timeout busak_n=%b", bus.busak_n);
    end
  endtask

  task automatic wait_release();
    int c;
    c = 0;
    while (bus.busak_n != 2'b11 && c < 60) begin
      tick(1);
      c++;
    end
    if (bus.busak_n != 2'b11) begin
      n_checks++;
      n_errors++;
      $display("FAIL release_wait timeout busak_n=%b", bus.busak_n);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    low_cycles       = 0;
    both_low_cycles  = 0;
    cpu_auto         = 1'b0;
    reset_n          = 1'b1;
    bus.atnrq_n      = 8'hFF;
    bus.atn_mask     = 7'h7F;
    bus.busrq_n      = 2'b11;
    bus.cpu_busak_n  = 1'b1;
    bus.cpu_iack_n   = 1'b1;
    #2 reset_n = 1'b0;
    #11;
    chk("rst_int_n", bus.cpu_int_n, 1'b1);
    chk("rst_nmi_n", bus.cpu_nmi_n, 1'b1);
    chk("rst_addr_oe", bus.addr_oe, 1'b0);
    chk("rst_addr", bus.addr, 3'd0);
    chk("rst_busak_n", bus.busak_n, 2'b11);
    chk("rst_cpu_busrq_n", bus.cpu_busrq_n, 1'b1);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Lines 3 and 5 asserted: vector 5, INT after 3 edges
    bus.atnrq_n = 8'b1101_0111;
    tick(2);
    chk("int_before_3", bus.cpu_int_n, 1'b1);
    tick(1);
    chk("int_after_3", bus.cpu_int_n, 1'b0);
    chk("nmi_idle", bus.cpu_nmi_n, 1'b1);
    bus.cpu_iack_n = 1'b0;
    tick(1);
    chk("vec_addr", bus.addr, 3'd5);
    chk("vec_oe", bus.addr_oe, 1'b1);
    bus.atnrq_n = 8'b0101_0111;
    tick(4);
    chk("frozen_addr", bus.addr, 3'd5);
    chk("frozen_oe", bus.addr_oe, 1'b1);
    bus.cpu_iack_n = 1'b1;
    tick(1);
    chk("oe_drop", bus.addr_oe, 1'b0);
    bus.cpu_iack_n = 1'b0;
    tick(1);
    chk("vec2_addr", bus.addr, 3'd7);
    chk("vec2_oe", bus.addr_oe, 1'b1);
    bus.cpu_iack_n = 1'b1;
    tick(1);

    // Everything masked, line 0 (NMI) and line 7 asserted
    bus.atn_mask = 7'b0;
    bus.atnrq_n  = 8'b0111_1110;
    tick(2);
    chk("nmi_before_3", bus.cpu_nmi_n, 1'b1);
    tick(1);
    chk("nmi_after_3", bus.cpu_nmi_n, 1'b0);
    chk("masked_int", bus.cpu_int_n, 1'b1);
    bus.cpu_iack_n = 1'b0;
    tick(1);
    chk("spur_addr", bus.addr, 3'd0);
    chk("spur_oe", bus.addr_oe, 1'b1);
    bus.cpu_iack_n = 1'b1;
    tick(1);
    chk("spur_oe_drop", bus.addr_oe, 1'b0);
    bus.atnrq_n  = 8'hFF;
    bus.atn_mask = 7'h7F;
    tick(4);
    chk("nmi_cleared", bus.cpu_nmi_n, 1'b1);

    // Round robin: both masters request continuously
    cpu_auto    = 1'b1;
    bus.busrq_n = 2'b00;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who);
      chk($sformatf("rr_grant%0d", k), who, k % 2);
      tick(2);
      if (who == 0) bus.busrq_n = 2'b01;
      else          bus.busrq_n = 2'b10;
      wait_release();
      bus.busrq_n = 2'b00;
    end
    bus.busrq_n = 2'b11;
    tick(8);
    chk("rr_never_both", both_low_cycles, 0);
    chk("rr_idle_busrq", bus.cpu_busrq_n, 1'b1);

    // Abort: master 1 withdraws before the CPU acknowledges
    cpu_auto        = 1'b0;
    bus.cpu_busak_n = 1'b1;
    g0              = low_cycles;
    bus.busrq_n     = 2'b01;
    tick(3);
    chk("busrq_lat_3", bus.cpu_busrq_n, 1'b1);
    tick(1);
    chk("busrq_lat_4", bus.cpu_busrq_n, 1'b0);
    bus.busrq_n = 2'b11;
    tick(6);
    chk("abort_busrq", bus.cpu_busrq_n, 1'b1);
    chk("abort_busak", bus.busak_n, 2'b11);
    chk("abort_no_grant", low_cycles, g0);

    // Reset while master 0 holds the bus
    cpu_auto    = 1'b1;
    bus.busrq_n = 2'b10;
    wait_grant(who);
    chk("mid_grant", bus.busak_n, 2'b10);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busak", bus.busak_n, 2'b11);
    chk("async_rst_busrq", bus.cpu_busrq_n, 1'b1);
    tick(2);
    reset_n     = 1'b1;
    bus.busrq_n = 2'b11;
    tick(4);
    chk("post_rst_busak", bus.busak_n, 2'b11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
